rect_plotter: RTL

RECT_PLOTTER -- requirements
Module: rect_plotter

---
 rtl/rect_plotter.sv | 115 +++++++++++
 1 files changed

// File: rtl/rect_plotter.sv
// Filled-rectangle rasteriser for the vga_adapter pixel port: accepts one
// rectangle request, clips it to the screen, and emits one pixel per clock.
module rect_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [7:0] req_w,
    input  logic [6:0] req_h,
    input  logic [2:0] req_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        PLOT,
        DONE
    } state_t;

    localparam logic [8:0] W_LIM = 9'(SCREEN_W);
    localparam logic [7:0] H_LIM = 8'(SCREEN_H);

    state_t     state;
    state_t     state_next;

    logic [8:0] x_sum;
    logic [8:0] x_end_next;
    logic [7:0] y_sum;
    logic [7:0] y_end_next;
    logic       empty;
    logic       accept;
    logic       last_col;
    logic       last_pix;

    logic [7:0] x_start;
    logic [8:0] x_end;
    logic [7:0] y_end;

    // Widened sums so a rectangle running off the right/bottom edge clips
    // instead of wrapping back to the left/top.
    always_comb begin
        x_sum      = {1'b0, req_x} + {1'b0, req_w};
        y_sum      = {1'b0, req_y} + {1'b0, req_h};
        x_end_next = ((x_sum > W_LIM) ? W_LIM : x_sum) - 9'd1;
        y_end_next = ((y_sum > H_LIM) ? H_LIM : y_sum) - 8'd1;
        empty      = (req_w == 8'd0) || (req_h == 7'd0) ||
                     ({1'b0, req_x} >= W_LIM) || ({1'b0, req_y} >= H_LIM);
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = req_valid && req_ready;
    assign last_col  = ({1'b0, x} == x_end);
    assign last_pix  = last_col && ({1'b0, y} == y_end);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = empty ? DONE : PLOT;
            PLOT:    if (last_pix) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // x/y always hold the pixel currently on the bus; the first pixel is
    // loaded straight from the request so it appears the cycle after accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
            x_start <= 8'd0;
            x_end   <= 9'd0;
            y_end   <= 8'd0;
        end else begin
            plot <= 1'b0;
            if (accept && !empty) begin
                x       <= req_x;
                y       <= req_y;
                colour  <= req_colour;
                plot    <= 1'b1;
                x_start <= req_x;
                x_end   <= x_end_next;
                y_end   <= y_end_next;
            end else if (state == PLOT && !last_pix) begin
                plot <= 1'b1;
                if (last_col) begin
                    x <= x_start;
                    y <= y + 7'd1;
                end else begin
                    x <= x + 8'd1;
                end
            end
        end
    end

endmodule
